// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB first) with a framed input stream and a one-cycle delayed pass-through.
// Define CRC8_APPEND_EN to shift the final CRC out on dout after the data bits.
`timescale 1ns/1ps

module crc8_serial #(
    parameter logic [7:0]  POLY      = 8'h07,
    parameter logic [7:0]  INIT      = 8'h00,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       din,
    input  logic       din_valid,
    output logic       busy,
    output logic [7:0] crc,
    output logic       done,
    output logic       dout,
    output logic       dout_valid
);

`ifdef CRC8_APPEND_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, APPEND = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t     state, state_next;
    logic [7:0] cnt;
    logic       accept;
    logic       last_bit;
    logic [7:0] crc_next;

`ifdef CRC8_APPEND_EN
    logic [7:0] shadow;
    logic [3:0] app_cnt;
    logic       app_end;
`endif

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path can infer a latch.
        accept     = (state == SHIFT) && din_valid;
        last_bit   = accept && (cnt == LAST_IDX);
        crc_next   = {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? POLY : 8'h00);
        state_next = state;
`ifdef CRC8_APPEND_EN
        // Count 8 marks the cycle after the last appended bit, where done is raised.
        app_end    = (state == APPEND) && (app_cnt == 4'd8);
`endif
        case (state)
            IDLE:    if (start) state_next = SHIFT;
`ifdef CRC8_APPEND_EN
            SHIFT:   if (last_bit) state_next = APPEND;
            APPEND:  if (app_end) state_next = IDLE;
`else
            SHIFT:   if (last_bit) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc        <= INIT;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
`ifdef CRC8_APPEND_EN
            shadow     <= '0;
            app_cnt    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            done       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        crc <= INIT;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        crc        <= crc_next;
                        cnt        <= cnt + 8'd1;
                        dout       <= din;
                        dout_valid <= 1'b1;
`ifdef CRC8_APPEND_EN
                        if (last_bit) begin
                            shadow  <= crc_next;
                            app_cnt <= '0;
                        end
`else
                        if (last_bit) done <= 1'b1;
`endif
                    end
                end
`ifdef CRC8_APPEND_EN
                APPEND: begin
                    if (app_end) begin
                        done <= 1'b1;
                    end else begin
                        dout       <= shadow[7];
                        shadow     <= {shadow[6:0], 1'b0};
                        dout_valid <= 1'b1;
                        app_cnt    <= app_cnt + 4'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial: a queue-based frame model checked every cycle, plus
// literal CRC vectors. A second instance (FRAME_LEN=72) runs the "123456789" check string.
`timescale 1ns/1ps

module tb_crc8_serial;

`ifdef CRC8_APPEND_EN
    localparam int B_WAIT = 10;
`else
    localparam int B_WAIT = 1;
`endif
    localparam int LEN_A = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start, din, din_valid;
    logic       busy, done, dout, dout_valid;
    logic [7:0] crc;

    logic       start_b, din_b, din_valid_b;
    logic       busy_b, done_b, dout_b, dout_valid_b;
    logic [7:0] crc_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    crc8_serial #(.POLY(8'h07), .INIT(8'h00), .FRAME_LEN(LEN_A)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .busy(busy), .crc(crc), .done(done), .dout(dout), .dout_valid(dout_valid)
    );

    crc8_serial #(.POLY(8'h07), .INIT(8'h00), .FRAME_LEN(72)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .din(din_b), .din_valid(din_valid_b),
        .busy(busy_b), .crc(crc_b), .done(done_b), .dout(dout_b), .dout_valid(dout_valid_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Remainder of M(x)*x^8 divided by x^8+x^2+x+1 (INIT is zero in this bench).
    function automatic logic [7:0] crc_of(input logic bits[$]);
        logic [8:0] rem;
        rem = '0;
        for (int i = 0; i < bits.size() + 8; i++) begin
            rem = {rem[7:0], (i < bits.size()) ? bits[i] : 1'b0};
            if (rem[8]) rem = rem ^ 9'h107;
        end
        return rem[7:0];
    endfunction

    // Frame-level model of the first instance: accepted bits queue plus append bookkeeping.
    logic       m_bits[$];
    logic       m_busy, m_done, m_dv, m_dout, m_app;
    logic [7:0] m_app_word;
    int         m_app_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_done     <= 1'b0;
            m_dv       <= 1'b0;
            m_dout     <= 1'b0;
            m_app      <= 1'b0;
            m_app_word <= '0;
            m_app_left <= 0;
            m_bits.delete();
        end else begin
            m_done <= 1'b0;
            m_dv   <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_bits.delete();
                end
            end else if (m_app) begin
                if (m_app_left > 0) begin
                    m_dout     <= m_app_word[3'(m_app_left - 1)];
                    m_dv       <= 1'b1;
                    m_app_left <= m_app_left - 1;
                end else begin
                    m_app  <= 1'b0;
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (din_valid) begin
                m_bits.push_back(din);
                m_dout <= din;
                m_dv   <= 1'b1;
                if (m_bits.size() == LEN_A) begin
`ifdef CRC8_APPEND_EN
                    m_app      <= 1'b1;
                    m_app_word <= crc_of(m_bits);
                    m_app_left <= 8;
`else
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
`endif
                end
            end
        end
    end

    // Outputs change on posedge; compare on the opposite edge.
    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("dout_valid", dout_valid, m_dv);
        check("crc", crc, crc_of(m_bits));
        if (m_dv) check("dout", dout, m_dout);
    end

`ifdef CRC8_APPEND_EN
    logic [7:0] dshift = '0;
    always @(posedge clk) if (dout_valid) dshift <= {dshift[6:0], dout};
`endif

    task automatic cyc(input logic s, input logic v, input logic d);
        @(negedge clk);
        start = s; din_valid = v; din = d;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) cyc(1'b0, 1'b1, w[i]);
    endtask

    task automatic finish_frame(input logic restart, input logic [7:0] exp_crc, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0; din_valid = 1'b0; din = 1'b0;
            if (done) begin
                seen  = 1'b1;
                start = restart;
                check(name, crc, exp_crc);
`ifdef CRC8_APPEND_EN
                check({name, "_tail"}, dshift, exp_crc);
`endif
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    task automatic frame_b();
        logic [7:0] msg [9];
        bit seen;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        check("b_busy_after_start", busy_b, 1'b1);
        for (int j = 0; j < 9; j++) begin
            for (int i = 7; i >= 0; i--) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk); din_valid_b = 1'b0;
                    check("b_no_early_done", done_b, 1'b0);
                end
                @(negedge clk);
                check("b_no_early_done", done_b, 1'b0);
                din_valid_b = 1'b1; din_b = msg[j][i];
            end
        end
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk); din_valid_b = 1'b0; din_b = 1'b0;
            if (done_b) begin
                seen = 1'b1;
                check("b_done_latency", k, B_WAIT);
                check("b_crc_check_string", crc_b, 8'hF4);
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL b_done_timeout: got no done expected done within 20 cycles");
        end
        @(negedge clk);
        check("b_done_one_cycle", done_b, 1'b0);
        check("b_crc_hold", crc_b, 8'hF4);
    endtask

    initial begin
        start = 1'b0; din = 1'b0; din_valid = 1'b0;
        start_b = 1'b0; din_b = 1'b0; din_valid_b = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dout_valid", dout_valid, 1'b0);
        check("rst_crc", crc, 8'h00);
        rst_n = 1'b1;

        cyc(1'b1, 1'b0, 1'b0);
        @(negedge clk); start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        send_word(16'h0100);
        finish_frame(1'b1, 8'h15, "crc_0100");
        send_word(16'h0001);
        finish_frame(1'b0, 8'h07, "crc_0001");

        // Start pulsed in the middle of a frame must be ignored.
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 15; i >= 0; i--) cyc(i == 8, 1'b1, 16'h0100 >> i);
        finish_frame(1'b0, 8'h15, "crc_midstart");

        // The din bit presented with start is not consumed.
        cyc(1'b1, 1'b1, 1'b1);
        send_word(16'h0100);
        finish_frame(1'b0, 8'h15, "crc_simul_start");

        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 15; i >= 11; i--) cyc(1'b0, 1'b1, 16'h0100 >> i);
        @(posedge clk);
        #2 rst_n = 1'b0; din_valid = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_crc", crc, 8'h00);
        check("midrst_done", done, 1'b0);
        check("midrst_dout_valid", dout_valid, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        send_word(16'h0100);
        finish_frame(1'b0, 8'h15, "crc_after_reset");

        frame_b();

        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc8_serial.md
# crc8_serial

Bit-serial CRC-8 generator that follows the lab's gate-level XOR stage: it consumes a framed serial bit stream and folds each bit into an 8-bit LFSR with XOR feedback. It passes the data through with one cycle of delay and reports the final CRC with a one-cycle done pulse. It feeds the transmit/compare logic downstream.

## Interface
- POLY, 8'h07, generator polynomial without the x^8 term
- INIT, 8'h00, CRC register value loaded on start and on reset
- FRAME_LEN, 16, data bits per frame; legal range 1..255
- clk  input  1  rising-edge clock; one clock domain
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begins a frame; sampled only in IDLE
- din  input  1  serial data bit, MSB of the frame first
- din_valid  input  1  din is valid this cycle
- busy  output  1  high in every state except IDLE
- crc  output  8  CRC register; holds the final value after done
- done  output  1  one-cycle pulse when the frame (and append, if enabled) completes
- dout  output  1  registered serial output
- dout_valid  output  1  dout is valid this cycle

## Operation
- All outputs are registered.
- Reset values: busy=0, done=0, dout=0, dout_valid=0, crc=INIT, state=IDLE, bit counter=0.
- The FSM has states IDLE, SHIFT and APPEND. APPEND exists only with the macro.
- IDLE:
  - start=1 loads crc=INIT and cnt=0, then the FSM goes to SHIFT.
  - din_valid is ignored.
- SHIFT, when din_valid=1:
  - fb = crc[7] ^ din.
  - crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 8'h00).
  - cnt <= cnt+1.
  - dout <= din and dout_valid <= 1.
- SHIFT, when din_valid=0:
  - crc and cnt hold.
  - dout_valid <= 0.
- Last bit of the frame (din_valid=1 while cnt==FRAME_LEN-1):
  - Without the macro, the FSM goes to IDLE and done is high in the next cycle.
  - With the macro, the FSM goes to APPEND.
- Gaps are allowed. Any number of din_valid=0 cycles between bits only stalls the frame.
- start while busy is ignored. It does not restart the frame.
- start and din_valid asserted in the same IDLE cycle: the frame starts, and that din bit is NOT consumed.
- crc holds its final value through IDLE until the next start.
- rst_n low mid-frame aborts the frame immediately, asynchronously, to the reset values. No done is produced.
- Counter width is 8 bits. It never wraps, because FRAME_LEN is at most 255.

## Timing
- start to busy=1: 1 cycle.
- Bit accepted at edge k: crc and dout reflect that bit after edge k.
- done, without the macro:
  - done is high in the cycle after the edge that accepts the last bit.
  - busy drops in that same cycle.
- done, with the macro:
  - done rises in the cycle after the 8th CRC bit is shifted out.
  - busy drops with it.
- A new start is accepted in the cycle that done is high. The FSM is in IDLE then, so back-to-back frames are possible.
- Throughput is 1 bit/cycle when din_valid is held high.

## Configuration
- Macro: CRC8_APPEND_EN.
- Defined:
  - After the last data bit, APPEND shifts crc out on dout MSB first, for 8 consecutive cycles with dout_valid=1.
  - din_valid is ignored during APPEND.
  - crc holds its final value; it is shifted through a separate 8-bit shadow register.
  - done follows the 8th appended bit.
- Undefined:
  - There is no APPEND state.
  - dout and dout_valid carry only the delayed data.
  - done follows the last data bit directly.

## Test plan
- Reset check: hold rst_n=0 → busy=0, done=0, dout_valid=0, crc=8'h00. Then release rst_n and pulse start → busy=1 on the next cycle.
- Single-frame vector: FRAME_LEN=16, stream 16'h0100 continuously → crc=8'h15 and done pulses exactly 1 cycle. Then stream 16'h0001 → crc=8'h07.
- Check string: FRAME_LEN=72, stream "123456789" (ASCII, MSB first) with random din_valid gaps → crc=8'hF4. The done timing depends only on the accepted bits.
- Busy and simultaneous events:
  - Pulse start in mid-frame → no restart, and the CRC is unchanged.
  - Start a frame with start and din_valid asserted together → that first din bit is not counted.
- Reset mid-frame: assert rst_n=0 after 5 bits → immediate IDLE, crc=INIT, no done. A following full frame of 16'h0100 → crc=8'h15.
- Append mode (CRC8_APPEND_EN defined), 16'h0100:
  - dout_valid stays high for 24 cycles.
  - The last 8 dout bits are 0,0,0,1,0,1,0,1.
  - done follows in the next cycle, and back-to-back frames are accepted.
